// File: rtl/pc_unit_if.sv
// Bundle of the decode-side signals feeding the PC unit and the PC state it returns.
// Handshake: an instruction is taken on a rising clk edge when valid=1 and stall=0
// while the unit is running; stall=1 or valid=0 holds the PC and suppresses any
// branch, and no ready signal is returned -- the only backpressure is the stall input.
interface pc_unit_if #(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 9,
  parameter int CNT_W  = 16
);
  logic              valid;
  logic              stall;
  logic [3:0]        opcode;
  logic [2:0]        cond;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] rs_data;
  logic [2:0]        flags;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              branch_taken;
  logic              flush;
  logic              halted;
  logic [CNT_W-1:0]  taken_cnt;
  logic              state_dbg;

  modport master (
    output valid, stall, opcode, cond, imm, rs_data, flags,
    input  pc, pc_plus, branch_taken, flush, halted, taken_cnt, state_dbg
  );

  modport slave (
    input  valid, stall, opcode, cond, imm, rs_data, flags,
    output pc, pc_plus, branch_taken, flush, halted, taken_cnt, state_dbg
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: registered PC with sequential increment, PC-relative and
// register-indirect conditional branches, sticky halt, stall hold, a one-cycle
// redirect/flush pulse and a saturating count of taken redirects.
module pc_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                IMM_W    = 9,
  parameter int                INC      = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input logic    clk,
  input logic    rst,
  pc_unit_if.slave bus
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] b_target;
  logic              cond_true;
  logic              accept;
  logic              flag_z, flag_v, flag_n;

  assign flag_z = bus.flags[2];
  assign flag_v = bus.flags[1];
  assign flag_n = bus.flags[0];

  // Sequential address and PC-relative target; both wrap naturally at ADDR_W bits.
  assign pc_plus  = pc_q + ADDR_W'(INC);
  assign b_target = pc_plus + (ADDR_W'($signed(bus.imm)) << 1);
  assign accept   = (state_q == S_RUN) && bus.valid && !bus.stall;

  // Branch condition evaluation from the {Z,V,N} flags.
  always_comb begin
    cond_true = 1'b0;
    case (bus.cond)
      3'b000:  cond_true = !flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = !flag_z && !flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = flag_z || (!flag_z && !flag_n);
      3'b101:  cond_true = flag_n || flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  // Next-state, next-PC, redirect pulse and counter update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    cnt_d   = cnt_q;
    if (accept) begin
      case (bus.opcode)
        OP_B: begin
          pc_d    = cond_true ? b_target : pc_plus;
          taken_d = cond_true && (b_target != pc_plus);
        end
        OP_BR: begin
          pc_d    = cond_true ? bus.rs_data : pc_plus;
          taken_d = cond_true && (bus.rs_data != pc_plus);
        end
        OP_HLT: begin
          state_d = S_HALTED;
        end
        default: begin
          pc_d = pc_plus;
        end
      endcase
    end
    // A branch landing on pc_plus is not a redirect, so it neither pulses nor counts.
    if (taken_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, PC, pulse and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus      = pc_plus;
  assign bus.branch_taken = taken_q;
  assign bus.flush        = taken_q;
  assign bus.halted       = (state_q == S_HALTED);
  assign bus.taken_cnt    = cnt_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus randomized instruction streams
// checked against an arithmetic reference model. Two instances run in lockstep,
// one with the default counter width and one with a 2-bit counter to exercise saturation.
module tb_pc_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(16), .IMM_W(9), .CNT_W(16)) if_a ();
  pc_unit_if #(.ADDR_W(16), .IMM_W(9), .CNT_W(2))  if_b ();

  pc_unit #(.ADDR_W(16), .IMM_W(9), .INC(2), .RESET_PC(16'h0000), .CNT_W(16))
    dut_main (.clk(clk), .rst(rst), .bus(if_a));
  pc_unit #(.ADDR_W(16), .IMM_W(9), .INC(2), .RESET_PC(16'h0000), .CNT_W(2))
    dut_sat (.clk(clk), .rst(rst), .bus(if_b));

  // ---------------- reference model state ----------------
  int  m_pc;
  int  m_cnt;
  int  m_cnt_sat;
  bit  m_halted;
  bit  m_taken;
  int  n_checks = 0;
  int  n_fail   = 0;
  logic [31:0] exp_q[$];

  // ---------------- checker ----------------
  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_ok(int c, bit z, bit v, bit n);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int wrap16(int x);
    return ((x % 65536) + 65536) % 65536;
  endfunction

  task automatic model_reset();
    m_pc      = 0;
    m_cnt     = 0;
    m_cnt_sat = 0;
    m_halted  = 1'b0;
    m_taken   = 1'b0;
  endtask

  task automatic model_step(bit v, bit s, int op, int c, int imm, int rs, int fl);
    int simm, tgt, seq;
    bit redirect;
    redirect = 1'b0;
    seq = wrap16(m_pc + 2);
    if (!m_halted && v && !s) begin
      if (op == 12 || op == 13) begin
        simm = (imm >= 256) ? imm - 512 : imm;
        tgt  = (op == 12) ? wrap16(seq + 2 * simm) : rs;
        if (cond_ok(c, fl[2], fl[1], fl[0])) begin
          redirect = (tgt != seq);
          m_pc = tgt;
        end else begin
          m_pc = seq;
        end
      end else if (op == 15) begin
        m_halted = 1'b1;
      end else begin
        m_pc = seq;
      end
    end
    m_taken = redirect;
    if (redirect) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_sat < 3) m_cnt_sat++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_inputs(bit v, bit s, int op, int c, int imm, int rs, int fl);
    if_a.valid = v;             if_b.valid = v;
    if_a.stall = s;             if_b.stall = s;
    if_a.opcode = 4'(op);       if_b.opcode = 4'(op);
    if_a.cond = 3'(c);          if_b.cond = 3'(c);
    if_a.imm = 9'(imm);         if_b.imm = 9'(imm);
    if_a.rs_data = 16'(rs);     if_b.rs_data = 16'(rs);
    if_a.flags = 3'(fl);        if_b.flags = 3'(fl);
  endtask

  task automatic check_all(string tag);
    logic [31:0] exp_pc;
    exp_pc = exp_q.pop_front();
    check_eq({tag, ".pc"},      32'(if_a.pc), exp_pc);
    check_eq({tag, ".pc_plus"}, 32'(if_a.pc_plus), 32'(wrap16(int'(exp_pc) + 2)));
    check_eq({tag, ".taken"},   32'(if_a.branch_taken), 32'(m_taken));
    check_eq({tag, ".flush"},   32'(if_a.flush), 32'(m_taken));
    check_eq({tag, ".halted"},  32'(if_a.halted), 32'(m_halted));
    check_eq({tag, ".cnt"},     32'(if_a.taken_cnt), 32'(m_cnt));
    check_eq({tag, ".sat_pc"},  32'(if_b.pc), exp_pc);
    check_eq({tag, ".sat_cnt"}, 32'(if_b.taken_cnt), 32'(m_cnt_sat));
  endtask

  // One clock: drive inputs mid-cycle, advance the model, check #1 after the edge.
  task automatic step(bit v, bit s, int op, int c, int imm, int rs, int fl, string tag);
    set_inputs(v, s, op, c, imm, rs, fl);
    model_step(v, s, op, c, imm, rs, fl);
    exp_q.push_back(32'(m_pc));
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    exp_q.push_back(32'(m_pc));
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
  endtask

  task automatic jump_to(int addr, string tag);
    step(1, 0, 13, 7, 0, addr, 0, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op, c, imm, rs, fl;
    bit v, s;
    set_inputs(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Sequential fetch from reset.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, "seq");

    // B EQ taken backwards, then not taken.
    jump_to(16'h0010, "br_0010");
    step(1, 0, 12, 1, 9'h1FC, 0, 3'b100, "b_eq_taken");
    jump_to(16'h0010, "br_0010b");
    step(1, 0, 12, 1, 9'h1FC, 0, 3'b000, "b_eq_not");

    // Stall holds PC and suppresses the branch until released.
    jump_to(16'h0020, "br_0020");
    step(1, 1, 13, 7, 0, 16'h0100, 0, "stall1");
    step(1, 1, 13, 7, 0, 16'h0100, 0, "stall2");
    step(1, 0, 13, 7, 0, 16'h0100, 0, "stall_rel");
    step(0, 0, 13, 7, 0, 16'h0200, 0, "invalid");

    // Halt, ignored branch, then asynchronous reset mid-cycle.
    jump_to(16'h0030, "br_0030");
    step(1, 0, 15, 0, 0, 0, 0, "hlt");
    step(1, 0, 12, 7, 8, 0, 0, "hlt_ign_b");
    step(1, 0, 0, 0, 0, 0, 0, "hlt_ign_seq");
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_rst.pc", 32'(if_a.pc), 32'h0);
    check_eq("async_rst.halted", 32'(if_a.halted), 32'h0);
    check_eq("async_rst.cnt", 32'(if_a.taken_cnt), 32'h0);
    check_eq("async_rst.taken", 32'(if_a.branch_taken), 32'h0);
    #1;
    rst = 1'b0;

    // Wrap and non-redirecting taken branch.
    jump_to(16'hFFFE, "br_fffe");
    step(1, 0, 0, 0, 0, 0, 0, "wrap");
    jump_to(16'h0040, "br_0040");
    step(1, 0, 12, 7, 0, 0, 0, "b_imm0");
    step(1, 0, 13, 7, 0, 16'h0044, 0, "br_to_plus");

    // Five back-to-back redirects (2-bit counter saturates).
    do_reset();
    for (int i = 0; i < 5; i++) jump_to((i + 1) * 16'h0100, "b2b");

    // Condition-code sweep with a B that always lands away from pc_plus.
    for (int cc = 0; cc < 8; cc++) begin
      for (int f = 0; f < 8; f++) step(1, 0, 12, cc, 9'h010, 0, f, "cond_sweep");
    end

    // Randomized instruction stream.
    for (int i = 0; i < 600; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        v  = ($urandom_range(0, 9) != 0);
        s  = ($urandom_range(0, 4) == 0);
        op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 7) != 0) op = 0;
        if ($urandom_range(0, 2) == 0) op = 12 + $urandom_range(0, 1);
        c  = $urandom_range(0, 7);
        imm = (op == 12 && $urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 511);
        rs = ($urandom_range(0, 3) == 0) ? wrap16(m_pc + 2) : $urandom_range(0, 65535);
        fl = $urandom_range(0, 7);
        step(v, s, op, c, imm, rs, fl, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
